instr_fetch_queue: RTL and testbench
====================================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, sets queue capacity in instruction words (power of two, 2..16).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, sets the first fetch address after reset.
REQ-003 The ports SHALL be as follows; clk_i is the single clock, and rst_i is an asynchronous, active-low reset.
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  reset; asynchronous assert, active-low.
- redirect_i  input  1  branch/jump taken; flush and refetch.
- redirect_pc_i  input  32  new fetch address when redirect_i=1.
- mem_req_o  output  1  fetch request to instruction memory.
- mem_addr_o  output  32  fetch address; word aligned.
- mem_ack_i  input  1  memory returns mem_data_i this cycle.
- mem_data_i  input  32  fetched instruction word.
- instr_valid_o  output  1  head entry valid for the decoder.
- instr_o  output  32  head instruction word.
- instr_pc_o  output  32  address of the head instruction.
- instr_ready_i  input  1  decoder consumes head when instr_valid_o=1.
- count_o  output  $clog2(DEPTH)+1  number of valid queue entries.

Function
REQ-004 Internal state SHALL be fetch_pc (32b), a circular buffer of DEPTH {word, pc} entries, and read/write pointers with a count.
REQ-005 The FSM SHALL have 3 states: IDLE (no outstanding request), REQ (request outstanding), and DISCARD (request outstanding, result to be dropped).
REQ-006 IDLE->REQ: no redirect and count_o < DEPTH.
- mem_req_o=1 and mem_addr_o=fetch_pc, both registered and held stable until ack.
REQ-007 The block SHALL allow at most one outstanding request; mem_req_o=1 in both REQ and DISCARD.
REQ-008 REQ with mem_ack_i=1:
- Write {mem_data_i, fetch_pc} at the tail.
- fetch_pc += 4, wrapping 32'hFFFF_FFFC->0.
- Next state is REQ if space remains after this cycle's enqueue/dequeue, else IDLE.
- Back-to-back requests are therefore permitted.
REQ-009 A request SHALL issue only when a free slot is guaranteed, so an ack never overflows the queue.
REQ-010 Dequeue occurs on instr_valid_o && instr_ready_i; enqueue and dequeue in the same cycle leave count unchanged.
REQ-011 Output SHALL be first-word-fall-through:
- instr_valid_o = (count_o != 0).
- instr_o and instr_pc_o show the head entry combinationally from registered storage.
- Enqueue-to-visible latency is 1 cycle after the ack edge.
REQ-012 Redirect handling:
- redirect_i=1 flushes all entries (count->0, pointers equal) in that edge.
- fetch_pc <= {redirect_pc_i[31:2], 2'b00}.
- A same-cycle dequeue or ack is ignored.
REQ-013 Redirect while in REQ without ack -> DISCARD.
- The pending address is held until mem_ack_i=1.
- That ack's data is dropped; next state is REQ with mem_addr_o = the redirect address.
REQ-014 Redirect in REQ on the same cycle as mem_ack_i -> data dropped; next state REQ at the redirect address.
REQ-015 Redirect in IDLE or DISCARD: IDLE -> REQ at the new address; DISCARD stays DISCARD with fetch_pc updated (the last redirect wins).
REQ-016 Dequeue on an empty queue SHALL be ignored; mem_ack_i in IDLE SHALL be ignored.

Reset
REQ-017 While rst_i=0, the block SHALL immediately force:
- state=IDLE, fetch_pc=RESET_PC, count_o=0.
- mem_req_o=0, mem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, instr_pc_o=0.
REQ-018 After rst_i deasserts, the first request SHALL issue on the following rising edge.
REQ-019 Reset mid-request abandons the outstanding request; any ack arriving during reset is ignored.

Verification
REQ-020 Streaming fetch: reset release, single-cycle acks returning 0x11,0x22,0x33, ready=1 -> instr_o 0x11/0x22/0x33 with instr_pc_o 0x0/0x4/0x8, one per cycle.
REQ-021 Fill: ready=0, DEPTH=4, acks every cycle -> count_o reaches 4, mem_req_o=0, no 5th request; ready=1 for one cycle -> one new request at 0x10.
REQ-022 Redirect during an outstanding request: request at 0x8 unacked, redirect_pc_i=0x103 -> DISCARD; ack data 0xDEAD dropped; next mem_addr_o=0x100; instr_valid_o=0 until its ack.
REQ-023 Simultaneous redirect, ack and dequeue, count=2 -> count_o=0, no word enqueued, next request at the redirect address.
REQ-024 Wrap-around: redirect to 0xFFFF_FFFC, acks 0xA, 0xB -> instr_pc_o 0xFFFF_FFFC then 0x0000_0000.
REQ-025 Async reset: assert rst_i=0 mid-cycle with count=3 -> all outputs reach their reset values before the next edge; a mem_ack_i asserted during reset has no effect.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: single-outstanding-request fetcher feeding a
// first-word-fall-through buffer of {word, pc} entries, with redirect flush.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     redirect_i,
  input  logic [31:0]              redirect_pc_i,
  output logic                     mem_req_o,
  output logic [31:0]              mem_addr_o,
  input  logic                     mem_ack_i,
  input  logic [31:0]              mem_data_i,
  output logic                     instr_valid_o,
  output logic [31:0]              instr_o,
  output logic [31:0]              instr_pc_o,
  input  logic                     instr_ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic            mem_req_q, mem_req_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     word_mem [DEPTH];
  logic [31:0]     pc_mem   [DEPTH];

  logic            enq_s;
  logic            deq_s;
  logic [31:0]     redirect_pc_s;
  logic [31:0]     next_pc_s;

  // Queue bookkeeping; a redirect wins over any same-cycle enqueue or dequeue.
  always_comb begin
    redirect_pc_s = {redirect_pc_i[31:2], 2'b00};
    next_pc_s     = fetch_pc_q + 32'd4;
    deq_s         = (count_q != {CW{1'b0}}) && instr_ready_i && !redirect_i;
    enq_s         = (state_q == REQ) && mem_ack_i && !redirect_i;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    if (redirect_i) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(enq_s);
      rd_ptr_d = rd_ptr_q + AW'(deq_s);
      count_d  = count_q + CW'(enq_s) - CW'(deq_s);
    end
  end

  // Fetch FSM: decides next state, fetch pc and the registered request.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      IDLE: begin
        if (redirect_i) begin
          fetch_pc_d = redirect_pc_s;
          state_d    = REQ;
        end else if (count_q < CW'(DEPTH)) begin
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (redirect_i) begin
          fetch_pc_d = redirect_pc_s;
          state_d    = mem_ack_i ? REQ : DISCARD;
        end else if (mem_ack_i) begin
          fetch_pc_d = next_pc_s;
          // Only keep requesting while the slot for the next ack is guaranteed.
          state_d    = (count_d < CW'(DEPTH)) ? REQ : IDLE;
        end else begin
          state_d = REQ;
        end
      end
      DISCARD: begin
        if (redirect_i) begin
          fetch_pc_d = redirect_pc_s;
        end else begin
          fetch_pc_d = fetch_pc_q;
        end
        state_d = mem_ack_i ? REQ : DISCARD;
      end
      default: begin
        state_d    = IDLE;
        fetch_pc_d = fetch_pc_q;
      end
    endcase
    mem_req_d  = (state_d != IDLE);
    // DISCARD keeps presenting the abandoned address until its ack arrives.
    mem_addr_d = (state_d == DISCARD) ? mem_addr_q : fetch_pc_d;
  end

  // State, pointer and request registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Entry storage; contents are only observable while counted valid.
  always_ff @(posedge clk_i) begin
    if (enq_s) begin
      word_mem[wr_ptr_q] <= mem_data_i;
      pc_mem[wr_ptr_q]   <= fetch_pc_q;
    end
  end

  assign mem_req_o     = mem_req_q;
  assign mem_addr_o    = mem_addr_q;
  assign count_o       = count_q;
  assign instr_valid_o = (count_q != {CW{1'b0}});
  assign instr_o       = instr_valid_o ? word_mem[rd_ptr_q] : 32'h0000_0000;
  assign instr_pc_o    = instr_valid_o ? pc_mem[rd_ptr_q]   : 32'h0000_0000;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed scoreboard bench for instr_fetch_queue (DEPTH=4, RESET_PC=0).
module tb_instr_fetch_queue;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;
  logic [2:0]  count_o;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } ent_t;

  ent_t sb[$];
  int   checks = 0;
  int   errors = 0;

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_ack_i     (mem_ack_i),
    .mem_data_i    (mem_data_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i),
    .count_o       (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Compare the visible head and occupancy against the scoreboard.
  task automatic check_head(input string tag);
    check({tag, "_count"}, {29'd0, count_o}, sb.size());
    if (sb.size() == 0) begin
      check({tag, "_valid"}, {31'd0, instr_valid_o}, 32'd0);
    end else begin
      check({tag, "_valid"}, {31'd0, instr_valid_o}, 32'd1);
      check({tag, "_instr"}, instr_o, sb[0].word);
      check({tag, "_pc"}, instr_pc_o, sb[0].pc);
    end
  endtask

  task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
    check({tag, "_req"}, {31'd0, mem_req_o}, {31'd0, req});
    if (req) check({tag, "_addr"}, mem_addr_o, addr);
  endtask

  task automatic ack(input logic [31:0] data, input logic [31:0] pc, input bit keep);
    mem_ack_i  = 1'b1;
    mem_data_i = data;
    if (keep) sb.push_back('{word: data, pc: pc});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   {31'd0, mem_req_o}, 32'd0);
    check({tag, "_addr"},  mem_addr_o, 32'd0);
    check({tag, "_valid"}, {31'd0, instr_valid_o}, 32'd0);
    check({tag, "_instr"}, instr_o, 32'd0);
    check({tag, "_pc"},    instr_pc_o, 32'd0);
    check({tag, "_count"}, {29'd0, count_o}, 32'd0);
  endtask

  initial begin
    rst_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0;
    mem_ack_i = 1'b0; mem_data_i = 32'd0; instr_ready_i = 1'b0;
    tick(); tick();
    check_reset_outputs("reset");
    rst_i = 1'b1;
    tick();
    check_req("first_req", 1'b1, 32'h0);

    // Streaming: one ack per cycle while the decoder always consumes.
    instr_ready_i = 1'b1;
    ack(32'h11, 32'h0, 1'b1);
    tick(); check_head("stream0");
    ack(32'h22, 32'h4, 1'b1);
    tick(); void'(sb.pop_front()); check_head("stream1");
    ack(32'h33, 32'h8, 1'b1);
    tick(); void'(sb.pop_front()); check_head("stream2");
    mem_ack_i = 1'b0;
    tick(); void'(sb.pop_front()); check_head("stream_drain");
    check_req("stream_next", 1'b1, 32'hC);

    // Fill from a fresh reset with the decoder stalled.
    instr_ready_i = 1'b0;
    rst_i = 1'b0; sb.delete();
    tick();
    rst_i = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      ack(32'h100 + i, 32'(4 * i), 1'b1);
      tick();
    end
    mem_ack_i = 1'b0;
    check_head("fill_full");
    check_req("fill_stop", 1'b0, 32'h0);
    ack(32'hBAD0, 32'h0, 1'b0);
    tick();
    mem_ack_i = 1'b0;
    check_head("ack_in_idle");
    check_req("fill_no5th", 1'b0, 32'h0);
    instr_ready_i = 1'b1;
    tick(); void'(sb.pop_front());
    instr_ready_i = 1'b0;
    check_head("fill_deq");
    tick();
    check_req("fill_refetch", 1'b1, 32'h10);
    check_head("fill_refetch");

    // Redirect while the request at 0x10 is unacknowledged.
    redirect_i = 1'b1; redirect_pc_i = 32'h103;
    tick(); sb.delete();
    redirect_i = 1'b0;
    check_head("discard_flush");
    check_req("discard_hold", 1'b1, 32'h10);
    instr_ready_i = 1'b1;
    ack(32'hDEAD, 32'h10, 1'b0);
    tick();
    mem_ack_i = 1'b0; instr_ready_i = 1'b0;
    check_head("discard_drop");
    check_req("discard_readdr", 1'b1, 32'h100);
    tick();
    check_head("discard_wait");
    ack(32'h55, 32'h100, 1'b1);
    tick();
    mem_ack_i = 1'b0;
    check_head("redirect_first");

    // Redirect, ack and dequeue together with two entries queued.
    ack(32'h66, 32'h104, 1'b1);
    tick();
    check_head("pre_combo");
    redirect_i = 1'b1; redirect_pc_i = 32'h200; instr_ready_i = 1'b1;
    ack(32'h77, 32'h108, 1'b0);
    tick(); sb.delete();
    redirect_i = 1'b0; mem_ack_i = 1'b0; instr_ready_i = 1'b0;
    check_head("combo_flush");
    check_req("combo_readdr", 1'b1, 32'h200);

    // Wrap-around of the fetch pc past the top of the address space.
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE;
    tick();
    redirect_i = 1'b0;
    check_req("wrap_discard", 1'b1, 32'h200);
    ack(32'hDEAD, 32'h200, 1'b0);
    tick();
    check_req("wrap_addr", 1'b1, 32'hFFFF_FFFC);
    ack(32'hA, 32'hFFFF_FFFC, 1'b1);
    tick();
    check_head("wrap_a");
    check_req("wrap_next", 1'b1, 32'h0);
    ack(32'hB, 32'h0, 1'b1);
    tick();
    mem_ack_i = 1'b0;
    instr_ready_i = 1'b1;
    tick(); void'(sb.pop_front());
    instr_ready_i = 1'b0;
    check_head("wrap_b");

    // Asynchronous reset in mid-cycle with three entries queued.
    ack(32'hC1, 32'h4, 1'b1);
    tick();
    ack(32'hC2, 32'h8, 1'b1);
    tick();
    mem_ack_i = 1'b0;
    check_head("pre_reset");
    #2;
    rst_i = 1'b0;
    mem_ack_i = 1'b1; mem_data_i = 32'hEEEE;
    #1;
    check_reset_outputs("async_reset");
    tick();
    check_reset_outputs("reset_ack_ignored");
    mem_ack_i = 1'b0;
    sb.delete();
    rst_i = 1'b1;
    tick();
    check_req("post_reset", 1'b1, 32'h0);
    check_head("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
